lsb_first_serializer: RTL

//  Parallel-to-serial stage directly upstream of the 8-bit right-shift register.
//  - Accepts a DATA_W-bit word over a valid/ready handshake and drives it out LSB first on ser_out.
//  - Supplies the shift-enable strobe (bit_en) for the downstream register.
//  - After DATA_W strobes the downstream register holds the word, with bit 0 at Q[0].

---
 rtl/serializer_pkg.sv | 14 +
 rtl/lsb_first_serializer_if.sv | 23 ++
 rtl/bit_period_timer.sv | 39 +++
 rtl/lsb_first_serializer.sv | 119 +++++++++++
 4 files changed

// File: rtl/serializer_pkg.sv
// rtl/serializer_pkg.sv - state type and counter-width helpers shared by the serializer files
package serializer_pkg;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PARITY} ser_state_t;

  function automatic int bit_cnt_w(input int data_w);
    return $clog2(data_w + 1);
  endfunction

  function automatic int div_cnt_w(input int clks_per_bit);
    return (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
  endfunction

endpackage

// File: rtl/lsb_first_serializer_if.sv
// rtl/lsb_first_serializer_if.sv - word handshake and serial-side signals of the serializer
interface lsb_first_serializer_if #(parameter int DATA_W = 8);

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              ser_out;
  logic              bit_en;
  logic              parity_slot;
  logic              busy;
  logic              frame_done;

  modport master (
    output in_valid, in_data,
    input  in_ready, ser_out, bit_en, parity_slot, busy, frame_done
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, ser_out, bit_en, parity_slot, busy, frame_done
  );

endinterface

// File: rtl/bit_period_timer.sv
// rtl/bit_period_timer.sv - bit-period divider; registered tick marks the last cycle of each period
module bit_period_timer #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic tick
);
  import serializer_pkg::*;

  localparam int            DW      = div_cnt_w(CLKS_PER_BIT);
  localparam logic [DW-1:0] LAST    = DW'(CLKS_PER_BIT - 1);
  localparam logic          ONE_CLK = (CLKS_PER_BIT == 1);

  logic [DW-1:0] div_cnt;
  logic [DW-1:0] div_inc;

  assign div_inc = div_cnt + DW'(1);

  // tick is computed one edge early so it is a flop output during the period's last cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else if (clear || (run && tick)) begin
      div_cnt <= '0;
      tick    <= ONE_CLK;
    end else if (run) begin
      div_cnt <= div_inc;
      tick    <= (div_inc == LAST);
    end else begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end
  end

endmodule

// File: rtl/lsb_first_serializer.sv
// rtl/lsb_first_serializer.sv - LSB-first word serializer; SERIALIZER_PARITY_EN adds an even-parity bit period
module lsb_first_serializer #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 1
) (
  input logic                   clk,
  input logic                   rst,
  lsb_first_serializer_if.slave bus
);
  import serializer_pkg::*;

  localparam int            BW       = bit_cnt_w(DATA_W);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  ser_state_t        state, state_nxt;
  logic [DATA_W-2:0] rest;
  logic [BW-1:0]     bit_idx;
  logic              ser_q;
  logic              ready;
  logic              accept;
  logic              tick;
  logic              last_data;
  logic              frame_end;
  logic              par_slot;
  logic              run;
`ifdef SERIALIZER_PARITY_EN
  logic              par_q;
`endif

  assign ready  = (state == S_IDLE) && !rst;
  assign accept = bus.in_valid && ready;
  assign run    = (state != S_IDLE) && !frame_end;

  bit_period_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (accept),
    .run   (run),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    last_data = 1'b0;
    frame_end = 1'b0;
    par_slot  = 1'b0;
    case (state)
      S_IDLE: if (accept) state_nxt = S_SHIFT;
      S_SHIFT: begin
        last_data = tick && (bit_idx == LAST_BIT);
        if (last_data) begin
`ifdef SERIALIZER_PARITY_EN
          state_nxt = S_PARITY;
`else
          state_nxt = S_IDLE;
          frame_end = 1'b1;
`endif
        end
      end
`ifdef SERIALIZER_PARITY_EN
      S_PARITY: begin
        par_slot = tick;
        if (tick) begin
          state_nxt = S_IDLE;
          frame_end = 1'b1;
        end
      end
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  // rest holds the bits still to come; ser_q already carries the current one
  always_ff @(posedge clk) begin
    if (rst) begin
      rest    <= '0;
      bit_idx <= '0;
      ser_q   <= 1'b0;
    end else if (accept) begin
      rest    <= bus.in_data[DATA_W-1:1];
      bit_idx <= '0;
      ser_q   <= bus.in_data[0];
    end else if (tick && (state == S_SHIFT)) begin
      if (last_data) begin
`ifdef SERIALIZER_PARITY_EN
        ser_q <= par_q;
`else
        ser_q <= 1'b0;
`endif
      end else begin
        ser_q   <= rest[0];
        rest    <= rest >> 1;
        bit_idx <= bit_idx + BW'(1);
      end
    end else if (frame_end) begin
      ser_q <= 1'b0;
    end
  end

`ifdef SERIALIZER_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst)         par_q <= 1'b0;
    else if (accept) par_q <= ^bus.in_data;
  end
`endif

  assign bus.in_ready    = ready;
  assign bus.ser_out     = ser_q;
  assign bus.bit_en      = tick;
  assign bus.parity_slot = par_slot;
  assign bus.busy        = (state != S_IDLE);
  assign bus.frame_done  = frame_end;

endmodule
